// File: rtl/instr_queue.sv
// instr_queue: circular FIFO of {pc, instr} pairs between fetch and decode.
// Flush empties the queue by resetting pointers; storage contents are left stale.
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int PTR_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             fetch_valid_i,
    input  logic [XLEN-1:0]  fetch_pc_i,
    input  logic [XLEN-1:0]  fetch_instr_i,
    input  logic             decode_ready_i,
    output logic             instr_valid_o,
    output logic [XLEN-1:0]  instr_pc_o,
    output logic [XLEN-1:0]  instr_o,
    output logic             instr_queue_ready_o,
    output logic [PTR_W:0]   count_o
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [2*XLEN-1:0] mem_q [DEPTH];
    logic [2*XLEN-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              push, pop;

    assign instr_valid_o       = count_q != '0;
    assign instr_queue_ready_o = count_q != FULL;
    assign {instr_pc_o, instr_o} = mem_q[rd_ptr_q];
    assign count_o             = count_q;

    always_comb begin
        push     = fetch_valid_i & instr_queue_ready_o & ~flush_i;
        pop      = instr_valid_o & decode_ready_i & ~flush_i;
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = {fetch_pc_i, fetch_instr_i};
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + PTR_W'(push);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + PTR_W'(pop);
        count_d  = flush_i ? '0 :
                   (push & ~pop) ? count_q + 1'b1 :
                   (pop & ~push) ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_n_i)
        count_q <= FULL && wr_ptr_q == rd_ptr_q + count_q[PTR_W-1:0]);
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: randomized and directed stimulus against a queue reference model;
// a negedge monitor checks count/flags/head and every consumed entry.
module tb_instr_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int PTR_W = 2;

    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             fetch_valid_i = 1'b0;
    logic [XLEN-1:0]  fetch_pc_i = '0;
    logic [XLEN-1:0]  fetch_instr_i = '0;
    logic             decode_ready_i = 1'b0;
    logic             instr_valid_o;
    logic [XLEN-1:0]  instr_pc_o;
    logic [XLEN-1:0]  instr_o;
    logic             instr_queue_ready_o;
    logic [PTR_W:0]   count_o;

    instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .PTR_W(PTR_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i),
        .fetch_instr_i(fetch_instr_i), .decode_ready_i(decode_ready_i),
        .instr_valid_o(instr_valid_o), .instr_pc_o(instr_pc_o), .instr_o(instr_o),
        .instr_queue_ready_o(instr_queue_ready_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef logic [2*XLEN-1:0] ent_t;
    ent_t model[$];
    ent_t exp_q[$];
    int   cur_cnt = 0;
    ent_t cur_head = '0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Inputs change 2 time units after the edge; the model advances to the state after the next edge.
    task automatic drive(input bit fv, input logic [XLEN-1:0] pc, input bit dr, input bit fl);
        @(posedge clk_i);
        #2;
        fetch_valid_i  = fv;
        fetch_pc_i     = pc;
        fetch_instr_i  = $urandom;
        decode_ready_i = dr;
        flush_i        = fl;
        cur_cnt  = model.size();
        cur_head = model.size() > 0 ? model[0] : '0;
        if (fl) model.delete();
        else begin
            bit full;
            full = model.size() == DEPTH;
            if (dr && model.size() > 0) exp_q.push_back(model.pop_front());
            if (fv && !full) model.push_back({pc, fetch_instr_i});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(instr_valid_o), 64'(0));
        chk({tag, "_pc"}, 64'(instr_pc_o), 64'(0));
        chk({tag, "_instr"}, 64'(instr_o), 64'(0));
        chk({tag, "_ready"}, 64'(instr_queue_ready_o), 64'(1));
        chk({tag, "_count"}, 64'(count_o), 64'(0));
    endtask

    always @(negedge clk_i) begin
        if (mon_en && rst_n_i) begin
            bit hs;
            hs = instr_valid_o && decode_ready_i && !flush_i;
            chk("count", 64'(count_o), 64'(cur_cnt));
            chk("valid", 64'(instr_valid_o), 64'(cur_cnt != 0));
            chk("ready", 64'(instr_queue_ready_o), 64'(cur_cnt != DEPTH));
            if (cur_cnt > 0) chk("head", {instr_pc_o, instr_o}, cur_head);
            chk("pop_taken", 64'(hs), 64'(exp_q.size() != 0));
            if (hs && exp_q.size() > 0) chk("pop_data", {instr_pc_o, instr_o}, exp_q.pop_front());
            exp_q.delete();
        end
    end

    initial begin
        #1 rst_n_i = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        cur_cnt = 0;
        mon_en  = 1'b1;
        repeat (2) drive(0, '0, 0, 0);
        // asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) drive(1, 32'h80 + 32'(i * 4), 0, 0);
        @(posedge clk_i);
        #2 fetch_valid_i = 1'b0;
        decode_ready_i = 1'b0;
        #1 rst_n_i = 1'b0;
        model.delete();
        exp_q.delete();
        #1 check_reset_outputs("midrst");
        @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        cur_cnt = 0;
        cur_head = '0;
        drive(0, '0, 0, 0);
        // fill to full, fifth push dropped, drain in order
        for (int i = 0; i < 5; i++) drive(1, 32'h100 + 32'(i * 4), 0, 0);
        repeat (5) drive(0, '0, 1, 0);
        // back-to-back push and pop, pointers wrap
        for (int i = 0; i < 10; i++) drive(1, 32'(i * 4), 1, 0);
        repeat (2) drive(0, '0, 1, 0);
        // full with simultaneous pop and fetch
        for (int i = 0; i < 4; i++) drive(1, 32'h300 + 32'(i * 4), 0, 0);
        drive(1, 32'h340, 1, 0);
        drive(0, '0, 0, 0);
        repeat (4) drive(0, '0, 1, 0);
        // flush with fetch and decode active
        for (int i = 0; i < 3; i++) drive(1, 32'h500 + 32'(i * 4), 0, 0);
        drive(1, 32'h400, 1, 1);
        drive(1, 32'h200, 0, 0);
        drive(0, '0, 0, 0);
        drive(0, '0, 1, 0);
        drive(0, '0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 10000; i++)
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0);
        repeat (6) drive(0, '0, 1, 0);
        drive(0, '0, 0, 0);
        @(posedge clk_i);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
